// File: rtl/controle_pkg.sv
// Shared types and constants for the NES controller reader: FSM states,
// button bit positions and a helper for sizing the cycle counter.
package controle_pkg;

  typedef enum logic [2:0] {
    ESPERA,
    LATCH,
    BAIXO,
    ALTO,
    FIM
  } estado_t;

  localparam logic [2:0] BTN_A      = 3'd0;
  localparam logic [2:0] BTN_B      = 3'd1;
  localparam logic [2:0] BTN_SELECT = 3'd2;
  localparam logic [2:0] BTN_START  = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd5;
  localparam logic [2:0] BTN_LEFT   = 3'd6;
  localparam logic [2:0] BTN_RIGHT  = 3'd7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a single asynchronous bit; RESET_VAL lets the
// caller choose the idle level seen while in reset.
module sincronizador #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/controle_nes.sv
// NES controller reader: periodic latch + 8 shift clocks, active-low serial data.
// Optional scan-to-scan debounce enabled by defining CONTROLE_NES_DEBOUNCE_EN.
module controle_nes
  import controle_pkg::*;
#(
  parameter int PERIODO_SCAN = 833333,
  parameter int LATCH_CICLOS = 600,
  parameter int MEIO_PERIODO = 300
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] botoes,
  output logic       novo,
  output logic [7:0] pressionado
);

  localparam int MAX_P = max3(PERIODO_SCAN, LATCH_CICLOS, MEIO_PERIODO);
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] LIM_ESPERA = CNT_W'(PERIODO_SCAN - 1);
  localparam logic [CNT_W-1:0] LIM_LATCH  = CNT_W'(LATCH_CICLOS - 1);
  localparam logic [CNT_W-1:0] LIM_MEIO   = CNT_W'(MEIO_PERIODO - 1);

  estado_t          r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_idx, w_idx_next;
  logic             w_amostra;
  logic             w_dado;
  logic             r_latch, r_nclk, r_novo;
  logic [7:0]       r_raw, r_botoes, r_press;
`ifdef CONTROLE_NES_DEBOUNCE_EN
  logic [7:0]       r_prev;
`endif

  // Idle level of the controller line is high (nothing pressed).
  sincronizador #(.RESET_VAL(1'b1)) u_sinc (
    .i_clk (CLOCK_50),
    .i_rst (reset),
    .i_d   (nes_data),
    .o_q   (w_dado)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    w_amostra    = 1'b0;
    case (r_state)
      ESPERA: begin
        w_idx_next = 3'd0;
        if (r_cnt == LIM_ESPERA) w_state_next = LATCH;
      end
      LATCH: if (r_cnt == LIM_LATCH) w_state_next = BAIXO;
      BAIXO: begin
        if (r_cnt == LIM_MEIO) begin
          w_amostra    = 1'b1;
          w_state_next = (r_idx == BTN_RIGHT) ? FIM : ALTO;
        end
      end
      ALTO: begin
        if (r_cnt == LIM_MEIO) begin
          w_idx_next   = r_idx + 3'd1;
          w_state_next = BAIXO;
        end
      end
      FIM:     w_state_next = ESPERA;
      default: w_state_next = ESPERA;
    endcase
    if (w_state_next != r_state) w_cnt_next = '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= ESPERA;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_latch  <= 1'b0;
      r_nclk   <= 1'b0;
      r_raw    <= 8'h00;
      r_botoes <= 8'h00;
      r_novo   <= 1'b0;
      r_press  <= 8'h00;
`ifdef CONTROLE_NES_DEBOUNCE_EN
      r_prev   <= 8'h00;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      // Strobes decoded from the next state so the pins come straight off flops.
      r_latch <= (w_state_next == LATCH);
      r_nclk  <= (w_state_next == ALTO);
      r_novo  <= 1'b0;
      r_press <= 8'h00;
      if (w_amostra) r_raw[r_idx] <= ~w_dado;
      if (r_state == FIM) begin
`ifdef CONTROLE_NES_DEBOUNCE_EN
        r_prev <= r_raw;
        if (r_raw == r_prev) begin
          r_botoes <= r_raw;
          r_novo   <= 1'b1;
          r_press  <= r_raw & ~r_botoes;
        end
`else
        r_botoes <= r_raw;
        r_novo   <= 1'b1;
        r_press  <= r_raw & ~r_botoes;
`endif
      end
    end
  end

  assign nes_latch   = r_latch;
  assign nes_clk     = r_nclk;
  assign botoes      = r_botoes;
  assign novo        = r_novo;
  assign pressionado = r_press;

endmodule

// File: tb/tb_controle_nes.sv
// Directed bench for controle_nes with a behavioural NES pad model.
module tb_controle_nes;
  import controle_pkg::*;

  localparam int P = 10;
  localparam int L = 4;
  localparam int M = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       nes_data;
  logic       nes_latch, nes_clk, novo;
  logic [7:0] botoes, pressionado;

  logic [7:0] pad    = 8'h00;
  logic [7:0] pad_l  = 8'h00;
  logic [2:0] bitpos = 3'd0;
  logic       latch_ant = 1'b0, clk_ant = 1'b0, ev_latch_rise = 1'b0;
  int n_chk = 0, n_fail = 0, ciclo_n = 0;
  int lat_rise_cyc = 0, lat_rise_prev = 0;
  int clk_rises = 0, clk_run = 0, clk_min = 99, clk_max = 0;

  // Pad drives the current bit active-low.
  assign nes_data = ~pad_l[bitpos];

  always #10 CLOCK_50 = ~CLOCK_50;

  controle_nes #(
    .PERIODO_SCAN (P),
    .LATCH_CICLOS (L),
    .MEIO_PERIODO (M)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .nes_data    (nes_data),
    .nes_latch   (nes_latch),
    .nes_clk     (nes_clk),
    .botoes      (botoes),
    .novo        (novo),
    .pressionado (pressionado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample 1 ns after the edge, advance the pad model, check invariants.
  task automatic ciclo();
    @(posedge CLOCK_50);
    #1;
    ciclo_n++;
    ev_latch_rise = nes_latch && !latch_ant;
    if (ev_latch_rise) begin
      bitpos        = 3'd0;
      pad_l         = pad;
      lat_rise_prev = lat_rise_cyc;
      lat_rise_cyc  = ciclo_n;
    end
    if (nes_clk && !clk_ant) begin
      bitpos = bitpos + 3'd1;
      clk_rises++;
    end
    if (nes_clk) clk_run++;
    else if (clk_ant) begin
      if (clk_run < clk_min) clk_min = clk_run;
      if (clk_run > clk_max) clk_max = clk_run;
      clk_run = 0;
    end
    latch_ant = nes_latch;
    clk_ant   = nes_clk;
    chk("no_overlap", {31'b0, nes_latch & nes_clk}, 32'd0);
    if (!novo) chk("press_idle", {24'b0, pressionado}, 32'd0);
  endtask

  task automatic medir(output int n);
    n = 0;
    while (!nes_latch && n < 100) begin
      ciclo();
      n++;
    end
  endtask

  task automatic scan(input logic [7:0] v, output int n_novo,
                      output logic [7:0] b, output logic [7:0] p);
    int k;
    pad = v; n_novo = 0; b = 8'h00; p = 8'h00; k = 0;
    ev_latch_rise = 1'b0;
    while (!ev_latch_rise && k < 60) begin
      ciclo();
      k++;
    end
    chk("scan_start", {31'b0, ev_latch_rise}, 32'd1);
    repeat (36) begin
      ciclo();
      if (novo) begin
        n_novo++;
        b = botoes;
        p = pressionado;
      end
    end
  endtask

  initial begin
    int n, w, k, nn;
    logic [7:0] b, p;

    // Reset state
    repeat (3) ciclo();
    chk("rst_latch", {31'b0, nes_latch}, 32'd0);
    chk("rst_clk",   {31'b0, nes_clk},   32'd0);
    chk("rst_botoes", {24'b0, botoes},   32'd0);
    chk("rst_novo",  {31'b0, novo},      32'd0);
    chk("rst_press", {24'b0, pressionado}, 32'd0);

    // First scan timing after release
    reset = 1'b0;
    medir(n);
    chk("latch_delay", n, 32'd10);
    clk_rises = 0; clk_min = 99; clk_max = 0; clk_run = 0;
    w = 1;
    ciclo();
    while (nes_latch && w < 20) begin
      w++;
      ciclo();
    end
    chk("latch_width", w, 32'd4);
    k = 0;
    while (!novo && k < 60) begin
      ciclo();
      k++;
    end
    chk("novo_first", {31'b0, novo}, 32'd1);
    chk("clk_pulses", clk_rises, 32'd7);
    chk("clk_hi_min", clk_min, 32'd2);
    chk("clk_hi_max", clk_max, 32'd2);
    chk("scan0_botoes", {24'b0, botoes}, 32'd0);
    chk("scan0_press", {24'b0, pressionado}, 32'd0);
    ciclo();
    chk("novo_one_cycle", {31'b0, novo}, 32'd0);

`ifdef CONTROLE_NES_DEBOUNCE_EN
    scan(8'h80, nn, b, p);
    chk("scan_period", lat_rise_cyc - lat_rise_prev, 32'd45);
    chk("glitch_novo", nn, 32'd0);
    chk("glitch_botoes", {24'b0, botoes}, 32'd0);
    scan(8'h00, nn, b, p);
    chk("after_glitch_novo", nn, 32'd0);
    chk("after_glitch_botoes", {24'b0, botoes}, 32'd0);
    scan(8'h80, nn, b, p);
    chk("right1_novo", nn, 32'd0);
    scan(8'h80, nn, b, p);
    chk("right2_novo", nn, 32'd1);
    chk("right2_botoes", {24'b0, b}, 32'h80);
    chk("right2_press", {24'b0, p}, 32'h80);
    scan((8'h01 << BTN_A) | (8'h01 << BTN_START), nn, b, p);
    chk("as1_novo", nn, 32'd0);
    scan(8'h09, nn, b, p);
    chk("as2_novo", nn, 32'd1);
    chk("as2_botoes", {24'b0, b}, 32'h09);
    chk("as2_press", {24'b0, p}, 32'h09);
`else
    scan((8'h01 << BTN_A) | (8'h01 << BTN_START), nn, b, p);
    chk("scan_period", lat_rise_cyc - lat_rise_prev, 32'd45);
    chk("as_novo", nn, 32'd1);
    chk("as_botoes", {24'b0, b}, 32'h09);
    chk("as_press", {24'b0, p}, 32'h09);
    scan(8'h09, nn, b, p);
    chk("as_rep_novo", nn, 32'd1);
    chk("as_rep_botoes", {24'b0, b}, 32'h09);
    chk("as_rep_press", {24'b0, p}, 32'h00);
    scan(8'h08, nn, b, p);
    chk("relA_novo", nn, 32'd1);
    chk("relA_botoes", {24'b0, b}, 32'h08);
    chk("relA_press", {24'b0, p}, 32'h00);
    scan((8'h01 << BTN_RIGHT) | 8'h01, nn, b, p);
    chk("ra_botoes", {24'b0, b}, 32'h81);
    chk("ra_press", {24'b0, p}, 32'h81);
    scan(8'h09, nn, b, p);
    scan(8'h09, nn, b, p);
`endif
    chk("pre_rst_botoes", {24'b0, botoes}, 32'h09);

    // Asynchronous reset while nes_clk is high
    pad = 8'h09;
    k = 0;
    while (!nes_clk && k < 60) begin
      ciclo();
      k++;
    end
    chk("found_alto", {31'b0, nes_clk}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_latch", {31'b0, nes_latch}, 32'd0);
    chk("arst_clk",   {31'b0, nes_clk},   32'd0);
    chk("arst_botoes", {24'b0, botoes},   32'd0);
    chk("arst_novo",  {31'b0, novo},      32'd0);
    chk("arst_press", {24'b0, pressionado}, 32'd0);
    repeat (3) ciclo();
    reset = 1'b0;
    medir(n);
    chk("arst_latch_delay", n, 32'd10);

    // Reset at a spread of offsets into the scan
    for (int off = 0; off < 45; off += 4) begin
      repeat (off) ciclo();
      reset = 1'b1;
      #1;
      chk("sweep_lines", {30'b0, nes_latch, nes_clk}, 32'd0);
      chk("sweep_botoes", {24'b0, botoes}, 32'd0);
      ciclo();
      ciclo();
      reset = 1'b0;
      medir(n);
      chk("sweep_delay", n, 32'd10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_nes.md
CONTROLE_NES -- requirements
Module: controle_nes

Interface
REQ-001 SHALL have parameter PERIODO_SCAN, default 833333: idle cycles between scans (~60 Hz at 50 MHz).
REQ-002 SHALL have parameter LATCH_CICLOS, default 600: nes_latch high width in cycles (12 us).
REQ-003 SHALL have parameter MEIO_PERIODO, default 300: nes_clk half-period in cycles (6 us).
REQ-004 SHALL have port CLOCK_50 in 1: sole clock, rising edge.
REQ-005 SHALL have port reset in 1: asynchronous, active-high reset.
REQ-006 SHALL have port nes_data in 1: serial controller data from GPIO_1, asynchronous, low = pressed.
REQ-007 SHALL have port nes_latch out 1: parallel-load strobe to the controller.
REQ-008 SHALL have port nes_clk out 1: shift clock to the controller.
REQ-009 SHALL have port botoes out 8: button state, high = pressed; bits 0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-010 SHALL have port novo out 1: one-cycle pulse when botoes updates.
REQ-011 SHALL have port pressionado out 8: one-cycle press-edge flags, valid only with novo.

Function
REQ-012 SHALL pass nes_data through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM states ESPERA, LATCH, BAIXO, ALTO and FIM.
REQ-014 ESPERA: nes_latch=0 and nes_clk=0 for PERIODO_SCAN cycles, then go to LATCH with bit index = 0.
REQ-015 LATCH: nes_latch=1 for LATCH_CICLOS cycles, then go to BAIXO.
REQ-016 BAIXO: nes_clk=0 for MEIO_PERIODO cycles; on the last cycle, store ~synchronized data into raw bit [index].
REQ-017 After BAIXO, go to FIM if index=7; otherwise go to ALTO.
REQ-018 ALTO: nes_clk=1 for MEIO_PERIODO cycles, then increment index and go to BAIXO.
REQ-019 FIM SHALL last exactly one cycle: apply the update rule (REQ-026/027), then go to ESPERA.
REQ-020 Scan period = PERIODO_SCAN + LATCH_CICLOS + 15*MEIO_PERIODO + 1 cycles; no overlap between scans.
REQ-021 nes_latch and nes_clk SHALL be registered outputs, glitch-free, and never high together.
REQ-022 On update, pressionado SHALL equal new_botoes & ~old_botoes for exactly the novo cycle; otherwise 0.
REQ-023 botoes SHALL hold its value between updates.
REQ-024 Cycle counter width SHALL be sized by $clog2 of the largest parameter, and SHALL reload to 0 on every state change.

Reset
REQ-025 Asserting reset, including mid-scan, SHALL force ESPERA, counter=0, index=0, nes_latch=0, nes_clk=0, botoes=0, novo=0, pressionado=0, raw=0, prev=0; after release, the first scan begins PERIODO_SCAN cycles later.

Configuration
REQ-026 With CONTROLE_NES_DEBOUNCE_EN defined: in FIM, botoes is updated and novo pulsed only if raw equals the previous scan's raw value; prev is updated every scan.
REQ-027 Without CONTROLE_NES_DEBOUNCE_EN: in FIM, botoes<=raw and novo pulses after every scan, changed or not.

Structure
REQ-028 Shared package controle_pkg SHALL hold the FSM state enum and button index constants (BTN_A=0 ... BTN_RIGHT=7).
REQ-029 Sub-module sincronizador (2-flop, 1 bit) SHALL implement REQ-012.

Verification
All scenarios use a bench controller model; default test parameters are PERIODO_SCAN=10, LATCH_CICLOS=4, MEIO_PERIODO=2.
REQ-030 Reset release -> nes_latch rises exactly 10 cycles later and stays high 4 cycles; then 7 nes_clk pulses, each 2 cycles high; novo fires once per scan.
REQ-031 Model returns A+Start pressed (no debounce) -> botoes=8'h09 with novo, pressionado=8'h09; identical next scan -> novo pulses, pressionado=8'h00.
REQ-032 Release A only on the next scan -> botoes=8'h08, pressionado=8'h00.
REQ-033 Debounce on, one-scan glitch 8'h80 between 8'h00 scans -> botoes stays 8'h00 and no novo during the glitch; two consecutive 8'h80 scans -> botoes=8'h80, pressionado=8'h80.
REQ-034 Assert reset during ALTO with botoes=8'h09 -> all outputs 0 asynchronously; after release, the next nes_latch rises 10 cycles later.
REQ-035 Assert reset at all cycles -> nes_latch and nes_clk are never both 1.
